alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational 64-bit ALU between two requesters, for example the execute stage and an address/branch helper. Each requester has its own valid/ready request port and a response port; a round-robin FSM grants one request at a time. The arbiter registers the operands that drive the ALU, captures the ALU result one cycle later and holds it until the owner accepts it. It also flags opcodes the ALU does not implement.

## Interface
Parameters:
- XLEN, 64, operand/result width
- OPW, 4, ALU opcode width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid_i / req1_valid_i  in  1  request valid, port 0/1
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- req0_aluop_i / req1_aluop_i  in  OPW  opcode
- req0_op1_i / req1_op1_i  in  XLEN  operand 1
- req0_op2_i / req1_op2_i  in  XLEN  operand 2
- rsp0_valid_o / rsp1_valid_o  out  1  response valid, per owner
- rsp0_ready_i / rsp1_ready_i  in  1  owner accepts response
- rsp_result_o  out  XLEN  shared result bus
- rsp_err_o  out  1  opcode was unsupported
- alu_aluop_o  out  OPW  to ALU opcode
- alu_op1_o / alu_op2_o  out  XLEN  to ALU operands
- alu_result_i  in  XLEN  from ALU result
- busy_o  out  1  state != IDLE

## Operation
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - grant = port with valid; if both valid, port != last_grant.
  - reqN_ready_o = (state==IDLE) & reqN_valid_i & (grant==N). This is combinational; at most one ready is high.
  - On handshake: latch aluop/op1/op2 into the alu_* registers, owner <= N, last_grant <= N, err <= aluop not in {0,1,2,6,7,8}. Go to EXEC.
- **EXEC**: the alu_* registers are stable the whole cycle. result_reg <= alu_result_i. Go to RESP.
- **RESP**
  - rspN_valid_o = (owner==N). rsp_result_o = result_reg; rsp_err_o = err.
  - When rsp<owner>_ready_i is high, go to IDLE. No new grant is made in the same cycle.
- Unsupported opcodes (3,4,5,9..15) are still issued. The result is whatever the ALU returns, with rsp_err_o=1.
- Requester rule: operands must hold stable while valid is high and ready is low. The arbiter samples them only at the handshake.
- The rspN_ready_i of the non-owner is ignored. The rspN_valid_o of the non-owner is 0.
- Outputs outside RESP: rsp_result_o and rsp_err_o keep their last values. All rspN_valid_o are 0.
- Arithmetic is performed entirely by the ALU. The arbiter does no width conversion.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, last_grant=1 (port 0 wins first contention).
  - owner=0, err=0, result_reg=0.
  - alu_aluop_o=0, alu_op1_o=0, alu_op2_o=0.
  - All rsp valids 0, busy_o=0.
- Latency: handshake in cycle T, EXEC at T+1, rsp valid from T+2.
- Minimum issue interval is 3 cycles per operation: handshake T, response accepted T+2, next handshake T+3.
- Backpressure: RESP holds indefinitely. result, err and valid stay constant until ready.
- Simultaneous requests: the losing port's valid stays high with ready low. It is granted in the next IDLE cycle.
- Single requester repeating: that port is granted every time; the round-robin pointer does not starve it.
- Reset mid-operation (EXEC or RESP): the pending result is discarded and no response is produced. The next cycle is IDLE with reset values.
- A request that is valid during reset is not accepted. ready is 0 while rst_n=0.

## Test plan
Bench drives alu_result_i from a combinational model: add/sub/and/or/xor, 0 for other opcodes.
- Port 0 add, op1=5, op2=7, rsp0_ready=1 -> req0_ready at T, rsp0_valid at T+2 only, result=12, err=0, busy_o high T+1..T+2.
- Port 1 sub, op1=3, op2=5 -> rsp1_valid at T+2, result=0xFFFFFFFFFFFFFFFE, rsp0_valid=0.
- Both valid right after reset (port0 xor 0xF0^0xFF, port1 or 0x1|0x2):
  - port 0 granted first, result 0x0F;
  - port 1 granted at the next IDLE, result 0x3;
  - next contention grants port 0 again.
- Backpressure: rsp0_ready low for 4 cycles -> rsp0_valid, result and busy_o held for 4 cycles; req1_valid in that window gets no ready until after acceptance.
- Opcode 4'b0011 on port 0 -> response issued at T+2 with rsp_err_o=1.
- rst_n low during EXEC -> no rsp valid afterwards, all outputs at reset values; a new add 1+1 afterwards returns 2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU, the result is captured one cycle later and held until accepted.
module alu_arbiter #(
    parameter int XLEN = 64,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [OPW-1:0]  req0_aluop_i,
    input  logic [XLEN-1:0] req0_op1_i,
    input  logic [XLEN-1:0] req0_op2_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [OPW-1:0]  req1_aluop_i,
    input  logic [XLEN-1:0] req1_op1_i,
    input  logic [XLEN-1:0] req1_op2_i,
    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp_result_o,
    output logic            rsp_err_o,
    output logic [OPW-1:0]  alu_aluop_o,
    output logic [XLEN-1:0] alu_op1_o,
    output logic [XLEN-1:0] alu_op2_o,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            busy_o,
    output logic [1:0]      dbg_state_o
);

    // Handshake semantics: a transfer happens on a rising edge where valid and
    // ready are both high; valid never depends on ready, and request payload
    // must stay stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            owner;
    logic            err_q;
    logic [XLEN-1:0] result_q;
    logic [OPW-1:0]  aluop_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;

    logic            grant;
    logic            accept;
    logic            rsp_accept;
    logic [OPW-1:0]  sel_aluop;
    logic [XLEN-1:0] sel_op1;
    logic [XLEN-1:0] sel_op2;

    function automatic logic op_supported(input logic [OPW-1:0] op);
        logic ok;
        ok = 1'b0;
        if (op == OPW'(0) || op == OPW'(1) || op == OPW'(2) ||
            op == OPW'(6) || op == OPW'(7) || op == OPW'(8))
            ok = 1'b1;
        return ok;
    endfunction

    // On contention the port that did not win last time is favoured; a lone
    // requester always wins regardless of the pointer.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i)
            grant = ~last_grant;
        else if (req1_valid_i)
            grant = 1'b1;
    end

    always_comb begin
        sel_aluop = req0_aluop_i;
        sel_op1   = req0_op1_i;
        sel_op2   = req0_op2_i;
        if (grant) begin
            sel_aluop = req1_aluop_i;
            sel_op1   = req1_op1_i;
            sel_op2   = req1_op2_i;
        end
    end

    assign accept       = (state == IDLE) && rst_n && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && req0_valid_i && !grant;
    assign req1_ready_o = accept && req1_valid_i && grant;
    assign rsp_accept   = owner ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            aluop_q    <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        aluop_q    <= sel_aluop;
                        op1_q      <= sel_op1;
                        op2_q      <= sel_op2;
                        owner      <= grant;
                        last_grant <= grant;
                        err_q      <= !op_supported(sel_aluop);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result_i;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_accept)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_aluop_o  = aluop_q;
    assign alu_op1_o    = op1_q;
    assign alu_op2_o    = op2_q;
    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign rsp0_valid_o = (state == RESP) && !owner;
    assign rsp1_valid_o = (state == RESP) && owner;
    assign busy_o       = (state != IDLE);
    assign dbg_state_o  = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: one task per scenario, inline comparisons,
// bench-side ALU model (0 add, 1 sub, 6 or, 7 and, 8 xor, others return 0).
module tb_alu_arbiter;

    localparam int XLEN = 64;
    localparam int OPW  = 4;

    logic            clk;
    logic            rst_n;
    logic            req0_valid_i, req1_valid_i;
    logic            req0_ready_o, req1_ready_o;
    logic [OPW-1:0]  req0_aluop_i, req1_aluop_i;
    logic [XLEN-1:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic            rsp0_valid_o, rsp1_valid_o;
    logic            rsp0_ready_i, rsp1_ready_i;
    logic [XLEN-1:0] rsp_result_o;
    logic            rsp_err_o;
    logic [OPW-1:0]  alu_aluop_o;
    logic [XLEN-1:0] alu_op1_o, alu_op2_o;
    logic [XLEN-1:0] alu_result_i;
    logic            busy_o;
    logic [1:0]      dbg_state_o;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_aluop_i(req0_aluop_i), .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_aluop_i(req1_aluop_i), .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
        .alu_aluop_o(alu_aluop_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
        .alu_result_i(alu_result_i), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_model(input logic [OPW-1:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_result_i = alu_model(alu_aluop_o, alu_op1_o, alu_op2_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 0; req1_valid_i = 0;
        req0_aluop_i = '0; req0_op1_i = '0; req0_op2_i = '0;
        req1_aluop_i = '0; req1_op1_i = '0; req1_op2_i = '0;
        rsp0_ready_i = 1; rsp1_ready_i = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd9; req0_op2_i = 64'd9;
        rst_n = 0;
        tick();
        tick();
        checks++;
        if (req0_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req0_ready_o); end
        checks++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: busy/v0/v1/err got %b want 0000",
                               {busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o});
        end
        checks++;
        if ({rsp_result_o, alu_aluop_o, alu_op1_o, alu_op2_o} !== '0) begin
            errors++; $display("FAIL reset_regs: result %h op %h a %h b %h want all 0",
                               rsp_result_o, alu_aluop_o, alu_op1_o, alu_op2_o);
        end
        req0_valid_i = 0;
        rst_n = 1;
        tick();
    endtask

    task automatic test_port0_add();
        idle_inputs();
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd5; req0_op2_i = 64'd7;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o, busy_o} !== 3'b100) begin
            errors++; $display("FAIL add_T: ready0/ready1/busy got %b want 100", {req0_ready_o, req1_ready_o, busy_o});
        end
        tick();
        req0_valid_i = 0;
        #1;
        checks++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b100 || alu_op1_o !== 64'd5 || alu_op2_o !== 64'd7) begin
            errors++; $display("FAIL add_T1: busy/v0/v1 %b a %h b %h want 100 5 7",
                               {busy_o, rsp0_valid_o, rsp1_valid_o}, alu_op1_o, alu_op2_o);
        end
        tick();
        checks++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o} !== 4'b1100 || rsp_result_o !== 64'd12) begin
            errors++; $display("FAIL add_T2: busy/v0/v1/err %b result %h want 1100 c",
                               {busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o}, rsp_result_o);
        end
        tick();
        checks++;
        if ({busy_o, rsp0_valid_o} !== 2'b00 || rsp_result_o !== 64'd12) begin
            errors++; $display("FAIL add_T3: busy/v0 %b result %h want 00 c (held)", {busy_o, rsp0_valid_o}, rsp_result_o);
        end
    endtask

    task automatic test_port1_sub();
        idle_inputs();
        req1_valid_i = 1; req1_aluop_i = 4'd1; req1_op1_i = 64'd3; req1_op2_i = 64'd5;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            errors++; $display("FAIL sub_T: ready0/ready1 got %b want 01", {req0_ready_o, req1_ready_o});
        end
        tick();
        req1_valid_i = 0;
        tick();
        checks++;
        if ({rsp0_valid_o, rsp1_valid_o} !== 2'b01 || rsp_result_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL sub_T2: v0/v1 %b result %h want 01 fffffffffffffffe",
                               {rsp0_valid_o, rsp1_valid_o}, rsp_result_o);
        end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        idle_inputs();
        req0_valid_i = 1; req0_aluop_i = 4'd8; req0_op1_i = 64'hF0; req0_op2_i = 64'hFF;
        req1_valid_i = 1; req1_aluop_i = 4'd6; req1_op1_i = 64'h1; req1_op2_i = 64'h2;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("FAIL rr_first: ready0/ready1 got %b want 10", {req0_ready_o, req1_ready_o});
        end
        tick();
        req0_valid_i = 0;
        checks++;
        if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL rr_wait_exec: ready1 got %b want 0", req1_ready_o); end
        tick();
        checks++;
        if (rsp0_valid_o !== 1'b1 || rsp_result_o !== 64'h0F || req1_ready_o !== 1'b0) begin
            errors++; $display("FAIL rr_p0_rsp: v0 %b result %h ready1 %b want 1 f 0", rsp0_valid_o, rsp_result_o, req1_ready_o);
        end
        tick();
        checks++;
        if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL rr_second: ready1 got %b want 1", req1_ready_o); end
        tick();
        req1_valid_i = 0;
        tick();
        checks++;
        if (rsp1_valid_o !== 1'b1 || rsp_result_o !== 64'h3) begin
            errors++; $display("FAIL rr_p1_rsp: v1 %b result %h want 1 3", rsp1_valid_o, rsp_result_o);
        end
        tick();
        req0_valid_i = 1; req1_valid_i = 1;
        #1;
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("FAIL rr_third: ready0/ready1 got %b want 10", {req0_ready_o, req1_ready_o});
        end
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        rsp0_ready_i = 0;
        rsp1_ready_i = 1;
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd2; req0_op2_i = 64'd3;
        tick();
        req0_valid_i = 0;
        req1_valid_i = 1; req1_aluop_i = 4'd7; req1_op1_i = 64'hC; req1_op2_i = 64'hA;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp0_valid_o, rsp1_valid_o, busy_o, req1_ready_o} !== 4'b1010 || rsp_result_o !== 64'd5) begin
                errors++; $display("FAIL bp_hold[%0d]: v0/v1/busy/ready1 %b result %h want 1010 5",
                                   i, {rsp0_valid_o, rsp1_valid_o, busy_o, req1_ready_o}, rsp_result_o);
            end
            tick();
        end
        rsp0_ready_i = 1;
        #1;
        tick();
        checks++;
        if ({busy_o, rsp0_valid_o, req1_ready_o} !== 3'b001) begin
            errors++; $display("FAIL bp_release: busy/v0/ready1 %b want 001", {busy_o, rsp0_valid_o, req1_ready_o});
        end
        tick();
        req1_valid_i = 0;
        tick();
        checks++;
        if (rsp1_valid_o !== 1'b1 || rsp_result_o !== 64'h8) begin
            errors++; $display("FAIL bp_p1_rsp: v1 %b result %h want 1 8", rsp1_valid_o, rsp_result_o);
        end
        tick();
    endtask

    task automatic test_bad_opcode();
        idle_inputs();
        req0_valid_i = 1; req0_aluop_i = 4'b0011; req0_op1_i = 64'd9; req0_op2_i = 64'd4;
        tick();
        req0_valid_i = 0;
        #1;
        checks++;
        if (alu_aluop_o !== 4'b0011) begin errors++; $display("FAIL bad_issue: alu_aluop %h want 3", alu_aluop_o); end
        tick();
        checks++;
        if ({rsp0_valid_o, rsp_err_o} !== 2'b11 || rsp_result_o !== 64'd0) begin
            errors++; $display("FAIL bad_rsp: v0/err %b result %h want 11 0", {rsp0_valid_o, rsp_err_o}, rsp_result_o);
        end
        tick();
        // next good op must clear the error flag
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd4; req0_op2_i = 64'd4;
        tick();
        req0_valid_i = 0;
        tick();
        checks++;
        if ({rsp0_valid_o, rsp_err_o} !== 2'b10 || rsp_result_o !== 64'd8) begin
            errors++; $display("FAIL bad_clear: v0/err %b result %h want 10 8", {rsp0_valid_o, rsp_err_o}, rsp_result_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd20; req0_op2_i = 64'd22;
        tick();
        req0_valid_i = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o} !== 4'b0000 ||
            {rsp_result_o, alu_aluop_o, alu_op1_o, alu_op2_o} !== '0) begin
            errors++; $display("FAIL rst_mid: busy/v0/v1/err %b result %h a %h b %h want 0000 0 0 0",
                               {busy_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o}, rsp_result_o, alu_op1_o, alu_op2_o);
        end
        tick();
        checks++;
        if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_quiet: busy/v0/v1 %b want 000", {busy_o, rsp0_valid_o, rsp1_valid_o});
        end
        req0_valid_i = 1; req0_aluop_i = 4'd0; req0_op1_i = 64'd1; req0_op2_i = 64'd1;
        #1;
        checks++;
        if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: ready0 %b want 1", req0_ready_o); end
        tick();
        req0_valid_i = 0;
        tick();
        checks++;
        if (rsp0_valid_o !== 1'b1 || rsp_result_o !== 64'd2) begin
            errors++; $display("FAIL rst_mid_add: v0 %b result %h want 1 2", rsp0_valid_o, rsp_result_o);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_port0_add();
        test_port1_sub();
        test_contention();
        test_backpressure();
        test_bad_opcode();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
